// File: rtl/ipsxe_floating_point_invsqrt_a2lo_norm_v1_0_if.sv
// Valid/ready bus for the a2_lo normalisation stage: the input handshake with
// the 48-bit APM result, and the output handshake with the normalised fields.
interface ipsxe_floating_point_invsqrt_a2lo_norm_v1_0_if #(
    parameter int OUT_WIDTH = 24
);
    logic                 i_valid;
    logic                 o_ready;
    logic [47:0]          i_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_sign;
    logic                 o_zero;
    logic [OUT_WIDTH-1:0] o_mant;
    logic [5:0]           o_msb_pos;

    // The normaliser sits on the slave side of this bus
    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_sign, o_zero, o_mant, o_msb_pos
    );

    // Whoever feeds data in and collects results uses the master side
    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_sign, o_zero, o_mant, o_msb_pos
    );
endinterface

// File: rtl/ipsxe_floating_point_invsqrt_a2lo_norm_v1_0.sv
// Normalisation of the signed 48-bit APM post-adder result (a2_lo +/- a3*y)
// for the inverse-square-root datapath. Produces the sign, the magnitude shifted
// so its leading one sits at the top bit (rounded to OUT_WIDTH bits, nearest-even),
// and the bit position of that leading one. Three register stages share a single
// enable, so the whole pipeline freezes while the output is held by the consumer.
module ipsxe_floating_point_invsqrt_a2lo_norm_v1_0 #(
    parameter int OUT_WIDTH = 24
) (
    input  logic i_clk,
    input  logic i_rst_n,
    ipsxe_floating_point_invsqrt_a2lo_norm_v1_0_if.slave bus
);

    logic                 en;

    logic                 v1;
    logic [47:0]          d1;

    logic                 sign_c;
    logic [47:0]          mag_c;
    logic [5:0]           lzc_c;
    logic [47:0]          norm_c;

    logic                 v2;
    logic                 sign2;
    logic                 zero2;
    logic [5:0]           lzc2;
    logic [47:0]          norm2;

    logic [OUT_WIDTH-1:0] m_c;
    logic                 guard_c;
    logic                 sticky_c;
    logic                 round_up_c;
    logic [OUT_WIDTH:0]   sum_c;
    logic                 carry_c;

    logic                 v3;
    logic                 sign3;
    logic                 zero3;
    logic [OUT_WIDTH-1:0] mant3;
    logic [5:0]           pos3;

    // A full output that nobody takes freezes every stage at once
    assign en          = ~v3 | bus.i_ready;
    assign bus.o_ready = en;

    assign bus.o_valid   = v3;
    assign bus.o_sign    = sign3;
    assign bus.o_zero    = zero3;
    assign bus.o_mant    = mant3;
    assign bus.o_msb_pos = pos3;

    // Stage 1: capture the raw two's-complement word and its valid bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (en) begin
            v1 <= bus.i_valid;
            d1 <= bus.i_data;
        end
    end

    // Absolute value, leading-zero count (48 for a zero magnitude) and left shift
    always_comb begin
        sign_c = d1[47];
        mag_c  = sign_c ? (~d1 + 48'd1) : d1;
        lzc_c  = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (mag_c[i]) begin
                lzc_c = 6'(47 - i);
            end
        end
        norm_c = mag_c << lzc_c;
    end

    // Stage 2: hold the normalised magnitude together with its sign and shift
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            zero2 <= 1'b0;
            lzc2  <= '0;
            norm2 <= '0;
        end else if (en) begin
            v2    <= v1;
            sign2 <= sign_c;
            zero2 <= (mag_c == 48'd0);
            lzc2  <= lzc_c;
            norm2 <= norm_c;
        end
    end

    // Round-to-nearest-even on the top OUT_WIDTH bits; a carry out means the
    // mantissa wrapped to 2.0, so it becomes 1.0 and the leading one moves up
    always_comb begin
        m_c        = norm2[47 -: OUT_WIDTH];
        guard_c    = norm2[47 - OUT_WIDTH];
        sticky_c   = |norm2[46 - OUT_WIDTH:0];
        round_up_c = guard_c & (sticky_c | m_c[0]);
        sum_c      = {1'b0, m_c} + {{OUT_WIDTH{1'b0}}, round_up_c};
        carry_c    = sum_c[OUT_WIDTH];
    end

    // Stage 3: output registers; a zero input reports zero with cleared fields
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v3    <= 1'b0;
            sign3 <= 1'b0;
            zero3 <= 1'b0;
            mant3 <= '0;
            pos3  <= '0;
        end else if (en) begin
            v3 <= v2;
            if (zero2) begin
                sign3 <= 1'b0;
                zero3 <= 1'b1;
                mant3 <= '0;
                pos3  <= '0;
            end else begin
                sign3 <= sign2;
                zero3 <= 1'b0;
                mant3 <= carry_c ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : sum_c[OUT_WIDTH-1:0];
                pos3  <= 6'd47 - lzc2 + {5'd0, carry_c};
            end
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_invsqrt_a2lo_norm_v1_0.sv
// Self-checking bench for the a2_lo normalisation stage. Accepted inputs push
// their expected result onto a scoreboard; results are popped when they retire
// and compared against the queue head while they are stalled.
module tb_ipsxe_floating_point_invsqrt_a2lo_norm_v1_0;

    localparam int OUT_WIDTH = 24;

    typedef struct {
        logic [47:0]          data;
        logic                 sign;
        logic                 zero;
        logic [OUT_WIDTH-1:0] mant;
        logic [5:0]           pos;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int compared   = 0;
    int mismatched = 0;
    int retired    = 0;

    vec_t sb[$];

    ipsxe_floating_point_invsqrt_a2lo_norm_v1_0_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

    ipsxe_floating_point_invsqrt_a2lo_norm_v1_0 #(.OUT_WIDTH(OUT_WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference: find the leading one, then round the discarded tail by comparing it with one half
    function automatic vec_t model(input logic [47:0] d);
        vec_t        r;
        logic [63:0] mag;
        logic [63:0] m;
        logic [63:0] rem;
        logic [63:0] half;
        int          p;
        int          sh;
        r.data = d;
        mag = {16'd0, d};
        if (d[47]) mag = 64'h0001_0000_0000_0000 - {16'd0, d};
        if (mag == 64'd0) begin
            r.sign = 1'b0;
            r.zero = 1'b1;
            r.mant = '0;
            r.pos  = '0;
            return r;
        end
        p = 0;
        for (int i = 0; i < 48; i++) if (mag[i]) p = i;
        if (p < OUT_WIDTH) begin
            m = mag << (OUT_WIDTH - 1 - p);
        end else begin
            sh   = p - (OUT_WIDTH - 1);
            m    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 64'd1;
            if (m[OUT_WIDTH]) begin
                m = m >> 1;
                p = p + 1;
            end
        end
        r.sign = d[47];
        r.zero = 1'b0;
        r.mant = m[OUT_WIDTH-1:0];
        r.pos  = 6'(p);
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares a valid output with the scoreboard head; pops it only when it retires
    task automatic checkOutput();
        vec_t  e;
        string tag;
        if (bus.o_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_output: got mant %0h pos %0d expected no output",
                         bus.o_mant, bus.o_msb_pos);
            end else begin
                e   = sb[0];
                tag = bus.i_ready ? "retire" : "stall";
                checkVal({tag, "_sign"}, 64'(bus.o_sign), 64'(e.sign));
                checkVal({tag, "_zero"}, 64'(bus.o_zero), 64'(e.zero));
                checkVal({tag, "_mant"}, 64'(bus.o_mant), 64'(e.mant));
                checkVal({tag, "_pos"},  64'(bus.o_msb_pos), 64'(e.pos));
                if (bus.i_ready) begin
                    void'(sb.pop_front());
                    retired++;
                end
            end
        end
    endtask

    // One cycle: drive at the falling edge, sample shortly after, record a transfer
    task automatic applyStimulus(input logic v, input vec_t e, input logic r, output logic acc);
        @(negedge clk);
        bus.i_valid = v;
        bus.i_data  = e.data;
        bus.i_ready = r;
        #1;
        checkOutput();
        acc = v & bus.o_ready;
        if (acc) sb.push_back(e);
    endtask

    task automatic drain();
        vec_t idle_v;
        logic acc;
        int   n;
        idle_v = '{default: '0};
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            applyStimulus(1'b0, idle_v, 1'b1, acc);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (4) applyStimulus(1'b0, idle_v, 1'b1, acc);
    endtask

    task automatic checkResetState(input string name);
        checkVal({name, "_o_valid"}, 64'(bus.o_valid), 64'd0);
        checkVal({name, "_o_sign"},  64'(bus.o_sign), 64'd0);
        checkVal({name, "_o_zero"},  64'(bus.o_zero), 64'd0);
        checkVal({name, "_o_mant"},  64'(bus.o_mant), 64'd0);
        checkVal({name, "_o_pos"},   64'(bus.o_msb_pos), 64'd0);
        checkVal({name, "_o_ready"}, 64'(bus.o_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        vec_t        idle_v;
        vec_t        e;
        logic        acc;
        logic        v;
        logic        r;
        logic [63:0] raw;
        logic [47:0] d;
        int          cnt;
        int          base;

        vecs[0] = '{48'h000000000001, 1'b0, 1'b0, 24'h800000, 6'd0};
        vecs[1] = '{48'hFFFFFFFFFFFF, 1'b1, 1'b0, 24'h800000, 6'd0};
        vecs[2] = '{48'h7FFFFFFFFFFF, 1'b0, 1'b0, 24'h800000, 6'd47};
        vecs[3] = '{48'h400000400000, 1'b0, 1'b0, 24'h800000, 6'd46};
        vecs[4] = '{48'h400000C00000, 1'b0, 1'b0, 24'h800002, 6'd46};
        vecs[5] = '{48'h000000000000, 1'b0, 1'b1, 24'h000000, 6'd0};
        vecs[6] = '{48'h800000000000, 1'b1, 1'b0, 24'h800000, 6'd47};
        vecs[7] = '{48'h000000000010, 1'b0, 1'b0, 24'h800000, 6'd4};
        idle_v  = '{default: '0};

        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b1;
        rst_n       = 1'b0;
        #1;
        checkResetState("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency of a lone input with an always-ready consumer
        applyStimulus(1'b1, vecs[0], 1'b1, acc);
        checkVal("first_accept", 64'(acc), 64'd1);
        cnt = 0;
        do begin
            applyStimulus(1'b0, idle_v, 1'b1, acc);
            cnt++;
        end while (!bus.o_valid && cnt < 10);
        checkVal("latency", 64'(cnt), 64'd3);
        drain();

        // Corner values streamed back to back
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i], 1'b1, acc);
            checkVal("table_accept", 64'(acc), 64'd1);
        end
        drain();

        // Backpressure: five values, consumer stalls for four cycles at first output
        base = retired;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, model(48'(k)), 1'b1, acc);
            checkVal("bp_accept", 64'(acc), 64'd1);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, model(48'd4), 1'b0, acc);
            checkVal("bp_o_valid", 64'(bus.o_valid), 64'd1);
            checkVal("bp_o_ready", 64'(bus.o_ready), 64'd0);
        end
        for (int k = 4; k <= 5; k++) begin
            cnt = 0;
            do begin
                applyStimulus(1'b1, model(48'(k)), 1'b1, acc);
                cnt++;
            end while (!acc && cnt < 10);
            checkVal("bp_resume_accept", 64'(acc), 64'd1);
        end
        drain();
        checkVal("bp_retired", 64'(retired - base), 64'd5);

        // Reset with three values in flight, then a fresh input
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, vecs[k], 1'b1, acc);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = retired;
        applyStimulus(1'b1, vecs[7], 1'b1, acc);
        checkVal("post_reset_accept", 64'(acc), 64'd1);
        drain();
        checkVal("post_reset_retired", 64'(retired - base), 64'd1);

        // Random traffic with random stalls on both sides
        for (int n = 0; n < 300; n++) begin
            raw = {$urandom, $urandom};
            d   = raw[47:0] >> $urandom_range(0, 47);
            if ($urandom_range(0, 1) == 1) d = ~d + 48'd1;
            if ($urandom_range(0, 19) == 0) d = '0;
            e   = model(d);
            acc = 1'b0;
            cnt = 0;
            while (!acc && cnt < 50) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) != 0);
                applyStimulus(v, e, r, acc);
                cnt++;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
